// File: rtl/seg_pkg.sv
// Shared constants and types for the BCD converter and seven-segment display path.
package seg_pkg;

  localparam int unsigned DIGITS = 6;
  localparam int unsigned NIB_W  = 4;
  localparam int unsigned BIN_W  = 20;
  localparam int unsigned BCD_W  = DIGITS * NIB_W;
  localparam int unsigned CNT_W  = 5;

  localparam logic [BIN_W-1:0] BCD_MAX = 20'd999999;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

endpackage

// File: rtl/bcd_add3.sv
// Double-dabble nibble correction: add 3 to any digit of 5 or more before the shift.
module bcd_add3
  import seg_pkg::*;
(
  input  logic [NIB_W-1:0] nib_in,
  output logic [NIB_W-1:0] nib_out
);

  assign nib_out = (nib_in >= NIB_W'(5)) ? nib_in + NIB_W'(3) : nib_in;

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Sequential 20-bit binary to 6-digit BCD converter, one shift-add-3 step per clock,
// clamping at 999999. Define BCD_BLANK_EN to add the registered leading-zero mask output.
module bin_to_bcd_seq
  import seg_pkg::*;
#(
  parameter int unsigned CONV_CYCLES = 20
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  input  logic [BIN_W-1:0] data_in,
  input  logic             data_valid,
  output logic             ready,
  output logic [BCD_W-1:0] bcd,
  output logic             bcd_valid,
  output logic             ovf
`ifdef BCD_BLANK_EN
  ,
  output logic [DIGITS-1:0] blank
`endif
);

  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(CONV_CYCLES - 1);

  state_t           state_q, state_d;
  logic [BIN_W-1:0] bin_q, bin_d;
  logic [BCD_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_pend_q, ovf_pend_d;
  logic [BCD_W-1:0] bcd_q, bcd_d;
  logic             ovf_q, ovf_d;
  logic             bcd_valid_q, bcd_valid_d;

  logic [BCD_W-1:0] acc_adj;
  logic [BCD_W-1:0] acc_shift;
  logic [BIN_W-1:0] bin_shift;
  logic             done;

  for (genvar g = 0; g < DIGITS; g++) begin : g_digit
    bcd_add3 u_add3 (
      .nib_in (acc_q[g*NIB_W +: NIB_W]),
      .nib_out(acc_adj[g*NIB_W +: NIB_W])
    );
  end

  assign acc_shift = {acc_adj[BCD_W-2:0], bin_q[BIN_W-1]};
  assign bin_shift = {bin_q[BIN_W-2:0], 1'b0};
  assign done      = (state_q == SHIFT) && (cnt_q == LAST_STEP);

  // Next-state and datapath update
  always_comb begin
    state_d     = state_q;
    bin_d       = bin_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    ovf_pend_d  = ovf_pend_q;
    bcd_d       = bcd_q;
    ovf_d       = ovf_q;
    bcd_valid_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (data_valid) begin
          state_d = SHIFT;
          acc_d   = '0;
          cnt_d   = '0;
          if (data_in > BCD_MAX) begin
            bin_d      = BCD_MAX;
            ovf_pend_d = 1'b1;
          end else begin
            bin_d      = data_in;
            ovf_pend_d = 1'b0;
          end
        end
      end
      SHIFT: begin
        acc_d = acc_shift;
        bin_d = bin_shift;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_STEP) begin
          bcd_d       = acc_shift;
          ovf_d       = ovf_pend_q;
          bcd_valid_d = 1'b1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q     <= IDLE;
      bin_q       <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
      ovf_pend_q  <= 1'b0;
      bcd_q       <= '0;
      ovf_q       <= 1'b0;
      bcd_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      bin_q       <= bin_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      ovf_pend_q  <= ovf_pend_d;
      bcd_q       <= bcd_d;
      ovf_q       <= ovf_d;
      bcd_valid_q <= bcd_valid_d;
    end
  end

  assign ready     = (state_q == IDLE);
  assign bcd       = bcd_q;
  assign ovf       = ovf_q;
  assign bcd_valid = bcd_valid_q;

`ifdef BCD_BLANK_EN
  logic [DIGITS-1:0] blank_q, blank_d;
  logic [DIGITS-1:0] blank_nxt;
  logic              upper_zero;

  // Digit 0 is never blanked so a zero value still shows one "0"
  always_comb begin
    blank_nxt  = '0;
    upper_zero = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      upper_zero   = upper_zero && (acc_shift[i*NIB_W +: NIB_W] == '0);
      blank_nxt[i] = upper_zero;
    end
    blank_d = done ? blank_nxt : blank_q;
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      blank_q <= '0;
    end else begin
      blank_q <= blank_d;
    end
  end

  assign blank = blank_q;
`endif

endmodule
